// File: rtl/wb_regfile.sv
// wb_regfile: 2^ADDR_W x DATA_W writeback register file, two comb read ports.
// Ports: clk, rst (sync, active-high), RWE/Res/C_Reg write, A_Reg/B_Reg -> A_Val/B_Val, busy.
// After reset a one-register-per-cycle clear sweep runs with busy high and reads forced to 0.
// Optional macro WB_BYPASS_EN: same-cycle write-to-read forwarding in READY.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RWE,
  input  logic [DATA_W-1:0] Res,
  input  logic [ADDR_W-1:0] C_Reg,
  input  logic [ADDR_W-1:0] A_Reg,
  input  logic [ADDR_W-1:0] B_Reg,
  output logic [DATA_W-1:0] A_Val,
  output logic [DATA_W-1:0] B_Val,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = C_Reg;
    wdata   = Res;
    if (rst) begin
      // Contents are left alone; the sweep that follows clears them.
      state_d = CLEAR;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          // Writeback is ignored here; the sweep owns the write port.
          we    = 1'b1;
          waddr = cnt_q;
          wdata = '0;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = READY;
        end
        READY: begin
          we = RWE;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign busy = (state_q == CLEAR);

  always_comb begin
    A_Val = '0;
    B_Val = '0;
    if (!busy) begin
      A_Val = mem_q[A_Reg];
      B_Val = mem_q[B_Reg];
`ifdef WB_BYPASS_EN
      if (RWE && (C_Reg == A_Reg)) A_Val = Res;
      if (RWE && (C_Reg == B_Reg)) B_Val = Res;
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of reset sweep, writes, hazard, reset cases.
// Expected values are hand-computed constants; bypass expectations follow WB_BYPASS_EN.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RWE;
  logic [15:0] Res;
  logic [7:0]  C_Reg;
  logic [7:0]  A_Reg;
  logic [7:0]  B_Reg;
  logic [15:0] A_Val;
  logic [15:0] B_Val;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  wb_regfile dut (
    .clk   (clk),
    .rst   (rst),
    .RWE   (RWE),
    .Res   (Res),
    .C_Reg (C_Reg),
    .A_Reg (A_Reg),
    .B_Reg (B_Reg),
    .A_Val (A_Val),
    .B_Val (B_Val),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    RWE = 1'b1; C_Reg = a; Res = d;
    tick();
    RWE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [15:0] exp);
    A_Reg = a; B_Reg = a;
    #1;
    chk({tag, "_a"}, 32'(A_Val), 32'(exp));
    chk({tag, "_b"}, 32'(B_Val), 32'(exp));
  endtask

  task automatic wait_sweep(input string tag, input int exp_len);
    int n = 0;
    int drop = 0;
    while (busy && n < 400) begin
      if (A_Val !== 16'h0) drop++;
      tick();
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_rd0"}, 32'(drop), 32'd0);
  endtask

  initial begin
    int gap;
    rst = 1'b1; RWE = 1'b0; Res = '0;
    C_Reg = '0; A_Reg = 8'h10; B_Reg = 8'h20;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_a", 32'(A_Val), 32'd0);
    chk("rst_b", 32'(B_Val), 32'd0);

    // Writes to 0xFF are offered on every sweep edge and must be dropped.
    rst = 1'b0;
    RWE = 1'b1; C_Reg = 8'hFF; Res = 16'hFFFF; A_Reg = 8'hFF;
    wait_sweep("sweep", 256);
    RWE = 1'b0;
    chk("ready_busy", 32'(busy), 32'd0);
    rd("clr00", 8'h00, 16'h0000);
    rd("clr80", 8'h80, 16'h0000);
    rd("clrff", 8'hFF, 16'h0000);

    wr(8'h12, 16'hBEEF);
    rd("wr12", 8'h12, 16'hBEEF);
    rd("wr13", 8'h13, 16'h0000);

    wr(8'h00, 16'h5A5A);
    rd("wr00", 8'h00, 16'h5A5A);

    wr(8'h05, 16'h00AA);
    RWE = 1'b1; C_Reg = 8'h05; Res = 16'h1234;
    A_Reg = 8'h05; B_Reg = 8'h06;
    #1;
`ifdef WB_BYPASS_EN
    chk("haz_same", 32'(A_Val), 32'h1234);
`else
    chk("haz_same", 32'(A_Val), 32'h00AA);
`endif
    chk("haz_other", 32'(B_Val), 32'h0000);
    tick();
    RWE = 1'b0;
    #1;
    chk("haz_next", 32'(A_Val), 32'h1234);

    for (int i = 0; i < 4; i++) wr(8'(i), 16'h1111);
    rd("fill3", 8'h03, 16'h1111);

    // Reset coincides with a write; reset wins.
    rst = 1'b1; RWE = 1'b1; C_Reg = 8'h02; Res = 16'h7777;
    A_Reg = 8'h01;
    tick();
    rst = 1'b0; RWE = 1'b0;
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_a", 32'(A_Val), 32'd0);

    gap = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (busy !== 1'b1) gap++;
    end
    rst = 1'b1;
    tick();
    if (busy !== 1'b1) gap++;
    rst = 1'b0;
    chk("mid_gap", 32'(gap), 32'd0);
    wait_sweep("mid", 256);
    for (int i = 0; i < 4; i++) rd($sformatf("reclr%0d", i), 8'(i), 16'h0);
    rd("reclr12", 8'h12, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file: the consumer of the MEM/WB pipeline register outputs (write enable, 16-bit result, 8-bit destination register index). Holds 256 × 16-bit architectural registers and serves two combinational read ports to the decode stage. After reset it runs a one-register-per-cycle clear sweep and holds `busy` high, so the pipeline stalls until the file is valid. An optional same-cycle write-to-read bypass is compiled in by macro.

## Interface
- `DATA_W`, default 16: register width.
- `ADDR_W`, default 8: register index width. Depth is 2^`ADDR_W` = 256.

- `clk` (in, 1): the single clock. All state updates on the rising edge.
- `rst` (in, 1): synchronous, active-high reset.
- `RWE` (in, 1): writeback write enable from MEM/WB.
- `Res` (in, `DATA_W`): writeback data.
- `C_Reg` (in, `ADDR_W`): writeback destination index.
- `A_Reg` (in, `ADDR_W`): read port A index.
- `B_Reg` (in, `ADDR_W`): read port B index.
- `A_Val` (out, `DATA_W`): read port A data, combinational.
- `B_Val` (out, `DATA_W`): read port B data, combinational.
- `busy` (out, 1): clear sweep in progress. Drives pipeline `stall`.

## Operation
- State machine, 1 bit: CLEAR and READY.
  - Sweep counter `cnt`, `ADDR_W` bits.
- `rst` = 1 at an edge:
  - state becomes CLEAR and `cnt` becomes 0.
  - Register contents are not touched at that edge.
  - This applies from any state, including mid-sweep; the sweep restarts from 0.
- CLEAR with `rst` = 0, at each edge:
  - `reg[cnt]` is written with 0 and `cnt` increments.
  - When `cnt` = 255, state becomes READY and `cnt` wraps to 0.
  - `RWE` is ignored for the whole of CLEAR; no writeback is performed.
- READY with `RWE` = 1, at an edge: `reg[C_Reg]` is written with `Res`.
  - No register is special; index 0 is writable.
- Reads:
  - In CLEAR, `A_Val` and `B_Val` are forced to 0.
  - In READY, `A_Val` = `reg[A_Reg]` and `B_Val` = `reg[B_Reg]`, subject to the bypass rule under Configuration.
  - `A_Reg` = `B_Reg` is legal; both ports return the same value.
- `busy` = 1 exactly when state is CLEAR. It is decoded from the state register, so it is glitch-free.

## Timing
- Reset values, after any edge with `rst` = 1:
  - state CLEAR, `busy` = 1, `cnt` = 0.
  - `A_Val` = `B_Val` = 0.
  - Register contents are undefined until cleared.
- Sweep length: call the last edge with `rst` high E0.
  - Edges E1 to E256 clear registers 0 to 255.
  - `busy` falls after E256.
  - The first accepted write is at E257.
  - Total: 256 cycles of `busy` after reset deasserts.
- Write latency: data written at edge E is visible on the read ports from E onward.
  - With bypass it is also visible in the cycle before E, when `RWE`, `C_Reg` and `Res` are presented.
- Read ports have no clock latency: pure combinational path from `A_Reg`/`B_Reg`.
- `rst` and `RWE` asserted together: reset wins and the write is dropped.
- `RWE` = 1 at E256 (the last CLEAR edge): the write is dropped. The upstream stage is stalled during `busy`, so this write is never a valid instruction.

## Configuration
- `WB_BYPASS_EN` defined: in READY, if `RWE` = 1 and `C_Reg` = `A_Reg`, then `A_Val` = `Res` in the same cycle. Port B behaves the same way using `B_Reg`. This removes the WB-to-decode hazard bubble.
- `WB_BYPASS_EN` undefined: read ports return stored contents only. A value being written is seen one cycle later, and the hazard unit inserts the bubble.
- In CLEAR, outputs are 0 regardless of the macro.

## Test plan
- Reset sweep:
  - Stimulus: `rst` = 1 for 2 cycles, then 0.
  - Response: `busy` = 1 for exactly 256 cycles, then 0. Reads of registers 0, 128 and 255 return 0x0000.
- Write then read:
  - Stimulus: after sweep, `RWE` = 1, `C_Reg` = 0x12, `Res` = 0xBEEF. Next cycle `RWE` = 0, `A_Reg` = `B_Reg` = 0x12.
  - Response: `A_Val` = `B_Val` = 0xBEEF. Register 0x13 still reads 0x0000.
- Same-cycle hazard:
  - Stimulus: `RWE` = 1, `C_Reg` = `A_Reg` = 0x05, `Res` = 0x1234. Register 0x05 previously holds 0x00AA.
  - Response with `WB_BYPASS_EN`: `A_Val` = 0x1234 in that cycle.
  - Response without it: `A_Val` = 0x00AA in that cycle, then 0x1234 the next cycle.
- Write during sweep:
  - Stimulus: `RWE` = 1, `C_Reg` = 0xFF, `Res` = 0xFFFF on every edge E1 to E256.
  - Response: register 0xFF reads 0x0000 after `busy` falls.
- Reset mid-sweep:
  - Stimulus: `rst` pulsed at E100 of the sweep.
  - Response: `busy` stays 1 continuously; the sweep restarts; `busy` falls 256 edges after the pulse ends.
- Reset with contents:
  - Stimulus: fill registers 0x00 to 0x03 with 0x1111, then assert `rst`.
  - Response: `A_Val` = 0 while `busy`. Registers 0x00 to 0x03 read 0x0000 after the sweep.
